// File: rtl/conv3x3_stream_engine_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine:
// kernel modes, normalisation shift, kernel coefficients and default geometry.
package conv3x3_stream_engine_pkg;

    typedef enum logic [1:0] {
        GAUSS   = 2'd0,
        SOBEL_X = 2'd1,
        SOBEL_Y = 2'd2,
        MAG     = 2'd3
    } kernel_mode_t;

    localparam int DEFAULT_IMAGE_WIDTH  = 512;
    localparam int DEFAULT_IMAGE_HEIGHT = 512;
    localparam int DEFAULT_PIXEL_WIDTH  = 8;
    localparam int GAUSS_SHIFT          = 4;

    // Kernels are indexed [row][col]; row 0 is the oldest (top) image row, col 2 the newest.
    typedef int kernel3_t [3][3];

    localparam kernel3_t GAUSSIAN_KERNEL_3 = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    localparam kernel3_t SOBEL_X_KERNEL    = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam kernel3_t SOBEL_Y_KERNEL    = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

endpackage

// File: rtl/conv3x3_stream_engine_line_buffer.sv
// One image row of pixel storage: reads the old value at i_addr and overwrites it
// with i_wdata on the same enabled cycle.
module conv3x3_stream_engine_line_buffer
    import conv3x3_stream_engine_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_IMAGE_WIDTH,
    parameter  int WIDTH  = DEFAULT_PIXEL_WIDTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution (Gaussian / Sobel-X / Sobel-Y / magnitude) over a raster
// image with valid/ready handshakes; the whole pipeline freezes while the output stalls.
module conv3x3_stream_engine
    import conv3x3_stream_engine_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
    parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  kernel_mode_t           i_mode,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_sof,
    input  logic [PIXEL_WIDTH-1:0] i_in_pixel,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [PIXEL_WIDTH-1:0] o_out_pixel,
    output logic                   o_out_sof,
    output logic                   o_out_eof
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    // Wide enough for the unsigned Gaussian sum and the signed Sobel sums.
    localparam int ACC_W = PIXEL_WIDTH + 5;
    localparam logic [COL_W-1:0]        COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PIXEL_WIDTH) - 1);

    logic                    w_stall;
    logic                    w_adv;
    logic                    w_beat;
    logic [COL_W-1:0]        r_col;
    logic [COL_W-1:0]        w_col;
    logic [COL_W-1:0]        w_colNext;
    logic [ROW_W-1:0]        r_row;
    logic [ROW_W-1:0]        w_row;
    logic [ROW_W-1:0]        w_rowNext;
    kernel_mode_t            r_mode;
    logic [PIXEL_WIDTH-1:0]  w_lb1Rd;
    logic [PIXEL_WIDTH-1:0]  w_lb2Rd;

    logic [PIXEL_WIDTH-1:0]  r_win [3][3];
    logic                    r_winValid;
    logic                    r_winSof;
    logic                    r_winEof;
    kernel_mode_t            r_winMode;

    logic signed [ACC_W-1:0] w_gauss;
    logic signed [ACC_W-1:0] w_gx;
    logic signed [ACC_W-1:0] w_gy;
    logic signed [ACC_W-1:0] r_s1Gauss;
    logic signed [ACC_W-1:0] r_s1Gx;
    logic signed [ACC_W-1:0] r_s1Gy;
    logic                    r_s1Valid;
    logic                    r_s1Sof;
    logic                    r_s1Eof;
    kernel_mode_t            r_s1Mode;

    logic signed [ACC_W-1:0] w_absX;
    logic signed [ACC_W-1:0] w_absY;
    logic signed [ACC_W-1:0] w_sel;
    logic [PIXEL_WIDTH-1:0]  w_result;
    logic                    r_outValid;
    logic [PIXEL_WIDTH-1:0]  r_outPixel;
    logic                    r_outSof;
    logic                    r_outEof;

    assign w_stall    = r_outValid & ~i_out_ready;
    assign w_adv      = ~w_stall;
    assign w_beat     = i_in_valid & w_adv;
    assign o_in_ready = w_adv;

    // An sof beat is treated as pixel (0,0) regardless of where the counters were.
    assign w_col = i_in_sof ? '0 : r_col;
    assign w_row = i_in_sof ? '0 : r_row;

    always_comb begin
        w_colNext = w_col + COL_W'(1);
        w_rowNext = w_row;
        if (w_col == COL_LAST) begin
            w_colNext = '0;
            w_rowNext = (w_row == ROW_LAST) ? '0 : w_row + ROW_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= GAUSS;
        end else if (w_beat) begin
            r_col <= w_colNext;
            r_row <= w_rowNext;
            if (i_in_sof) begin
                r_mode <= i_mode;
            end
        end
    end

    // lb1 holds row r-1 and feeds its evicted pixel into lb2, which holds row r-2.
    conv3x3_stream_engine_line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (PIXEL_WIDTH)
    ) u_lineBuf1 (
        .i_clk   (i_clk),
        .i_en    (w_beat),
        .i_addr  (w_col),
        .i_wdata (i_in_pixel),
        .o_rdata (w_lb1Rd)
    );

    conv3x3_stream_engine_line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (PIXEL_WIDTH)
    ) u_lineBuf2 (
        .i_clk   (i_clk),
        .i_en    (w_beat),
        .i_addr  (w_col),
        .i_wdata (w_lb1Rd),
        .o_rdata (w_lb2Rd)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_winValid <= 1'b0;
            r_winSof   <= 1'b0;
            r_winEof   <= 1'b0;
            r_winMode  <= GAUSS;
        end else if (w_adv) begin
            r_winValid <= w_beat && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
            r_winSof   <= w_beat && (w_row == ROW_W'(2)) && (w_col == COL_W'(2));
            r_winEof   <= w_beat && (w_row == ROW_LAST) && (w_col == COL_LAST);
            r_winMode  <= r_mode;
            if (w_beat) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb2Rd;
                r_win[1][2] <= w_lb1Rd;
                r_win[2][2] <= i_in_pixel;
            end
        end
    end

    // All three sums are formed every cycle so the magnitude mode has both gradients.
    always_comb begin
        w_gauss = '0;
        w_gx    = '0;
        w_gy    = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_gauss = w_gauss + ACC_W'(GAUSSIAN_KERNEL_3[i][j])
                        * $signed({{(ACC_W - PIXEL_WIDTH){1'b0}}, r_win[i][j]});
                w_gx    = w_gx + ACC_W'(SOBEL_X_KERNEL[i][j])
                        * $signed({{(ACC_W - PIXEL_WIDTH){1'b0}}, r_win[i][j]});
                w_gy    = w_gy + ACC_W'(SOBEL_Y_KERNEL[i][j])
                        * $signed({{(ACC_W - PIXEL_WIDTH){1'b0}}, r_win[i][j]});
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Sof   <= 1'b0;
            r_s1Eof   <= 1'b0;
            r_s1Mode  <= GAUSS;
            r_s1Gauss <= '0;
            r_s1Gx    <= '0;
            r_s1Gy    <= '0;
        end else if (w_adv) begin
            r_s1Valid <= r_winValid;
            r_s1Sof   <= r_winSof;
            r_s1Eof   <= r_winEof;
            r_s1Mode  <= r_winMode;
            r_s1Gauss <= w_gauss;
            r_s1Gx    <= w_gx;
            r_s1Gy    <= w_gy;
        end
    end

    always_comb begin
        w_absX = r_s1Gx[ACC_W-1] ? -r_s1Gx : r_s1Gx;
        w_absY = r_s1Gy[ACC_W-1] ? -r_s1Gy : r_s1Gy;
        w_sel  = '0;
        case (r_s1Mode)
            GAUSS:   w_sel = r_s1Gauss >>> GAUSS_SHIFT;
            SOBEL_X: w_sel = w_absX;
            SOBEL_Y: w_sel = w_absY;
            default: w_sel = w_absX + w_absY;
        endcase
        w_result = (w_sel > PIX_MAX) ? PIX_MAX[PIXEL_WIDTH-1:0] : w_sel[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_outValid <= 1'b0;
            r_outPixel <= '0;
            r_outSof   <= 1'b0;
            r_outEof   <= 1'b0;
        end else if (w_adv) begin
            r_outValid <= r_s1Valid;
            r_outPixel <= w_result;
            r_outSof   <= r_s1Valid & r_s1Sof;
            r_outEof   <= r_s1Valid & r_s1Eof;
        end
    end

    assign o_out_valid = r_outValid;
    assign o_out_pixel = r_outPixel;
    assign o_out_sof   = r_outSof;
    assign o_out_eof   = r_outEof;

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Randomised bench for conv3x3_stream_engine: a 5x5 instance and a 512-wide instance share
// one stimulus path, and every output beat is compared with an arithmetic reference model.
module tb_conv3x3_stream_engine;
    import conv3x3_stream_engine_pkg::*;

    localparam int SMALL_W = 5;
    localparam int SMALL_H = 5;
    localparam int BIG_W   = 512;
    localparam int BIG_H   = 6;

    localparam int IMG_FLAT   = 0;
    localparam int IMG_VSTEP  = 1;
    localparam int IMG_HSTEP  = 2;
    localparam int IMG_RANDOM = 3;

    typedef struct {
        int pix;
        int sof;
        int eof;
    } expect_t;

    logic         clk;
    logic         rstN;
    kernel_mode_t mode;
    logic         inValid;
    logic         inSof;
    logic [7:0]   inPixel;
    logic         outReady;
    logic         sel;
    logic         bpEnable;

    logic         aInReady, aOutValid, aOutSof, aOutEof;
    logic [7:0]   aOutPixel;
    logic         bInReady, bOutValid, bOutSof, bOutEof;
    logic [7:0]   bOutPixel;

    logic         inReady, outValid, outSof, outEof;
    logic [7:0]   outPixel;

    int           checkCount;
    int           failCount;
    expect_t      expQ[$];
    int           img[];
    int           curW;
    int           curH;

    conv3x3_stream_engine #(
        .IMAGE_WIDTH  (SMALL_W),
        .IMAGE_HEIGHT (SMALL_H),
        .PIXEL_WIDTH  (8)
    ) dutSmall (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_mode      (mode),
        .i_in_valid  (inValid & ~sel),
        .o_in_ready  (aInReady),
        .i_in_sof    (inSof),
        .i_in_pixel  (inPixel),
        .o_out_valid (aOutValid),
        .i_out_ready (outReady),
        .o_out_pixel (aOutPixel),
        .o_out_sof   (aOutSof),
        .o_out_eof   (aOutEof)
    );

    conv3x3_stream_engine #(
        .IMAGE_WIDTH  (BIG_W),
        .IMAGE_HEIGHT (BIG_H),
        .PIXEL_WIDTH  (8)
    ) dutBig (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_mode      (mode),
        .i_in_valid  (inValid & sel),
        .o_in_ready  (bInReady),
        .i_in_sof    (inSof),
        .i_in_pixel  (inPixel),
        .o_out_valid (bOutValid),
        .i_out_ready (outReady),
        .o_out_pixel (bOutPixel),
        .o_out_sof   (bOutSof),
        .o_out_eof   (bOutEof)
    );

    assign inReady  = sel ? bInReady  : aInReady;
    assign outValid = sel ? bOutValid : aOutValid;
    assign outPixel = sel ? bOutPixel : aOutPixel;
    assign outSof   = sel ? bOutSof   : aOutSof;
    assign outEof   = sel ? bOutEof   : aOutEof;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int pix(input int r, input int c);
        return img[r * curW + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Every accepted pixel at row>=2, col>=2 completes the window centred one up and one left.
    task automatic pushExpected(input int n, input kernel_mode_t m);
        int r, c, g, gx, gy;
        expect_t e;
        for (int k = 0; k < n; k++) begin
            r = k / curW - 1;
            c = k % curW - 1;
            if (r >= 1 && c >= 1) begin
                g  = pix(r-1, c-1) + 2*pix(r-1, c) + pix(r-1, c+1)
                   + 2*pix(r, c-1) + 4*pix(r, c) + 2*pix(r, c+1)
                   + pix(r+1, c-1) + 2*pix(r+1, c) + pix(r+1, c+1);
                gx = (pix(r-1, c+1) + 2*pix(r, c+1) + pix(r+1, c+1))
                   - (pix(r-1, c-1) + 2*pix(r, c-1) + pix(r+1, c-1));
                gy = (pix(r+1, c-1) + 2*pix(r+1, c) + pix(r+1, c+1))
                   - (pix(r-1, c-1) + 2*pix(r-1, c) + pix(r-1, c+1));
                case (m)
                    GAUSS:   e.pix = g / 16;
                    SOBEL_X: e.pix = sat255(iabs(gx));
                    SOBEL_Y: e.pix = sat255(iabs(gy));
                    default: e.pix = sat255(iabs(gx) + iabs(gy));
                endcase
                e.sof = (r == 1 && c == 1) ? 1 : 0;
                e.eof = (r == curH - 2 && c == curW - 2) ? 1 : 0;
                expQ.push_back(e);
            end
        end
    endtask

    task automatic fillImage(input int kind);
        img = new[curW * curH];
        for (int k = 0; k < curW * curH; k++) begin
            case (kind)
                IMG_FLAT:  img[k] = 100;
                IMG_VSTEP: img[k] = ((k % curW) >= 2) ? 255 : 0;
                IMG_HSTEP: img[k] = ((k / curW) >= 2) ? 255 : 0;
                default:   img[k] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic sendPixel(input int p, input bit s, input kernel_mode_t md);
        int waitCnt;
        bit rdy;
        inPixel = 8'(p);
        inSof   = s;
        mode    = md;
        inValid = 1'b1;
        waitCnt = 0;
        rdy     = 1'b0;
        while (!rdy && waitCnt < 200) begin
            @(negedge clk);
            rdy = inReady;
            @(posedge clk);
            #1;
            waitCnt++;
        end
        inValid = 1'b0;
        inSof   = 1'b0;
        if (!rdy) checkOutput("inAccept", int'(rdy), 1);
    endtask

    // Streams the first n pixels of a fresh image; the mode input is scrambled on non-sof beats.
    task automatic applyStimulus(input kernel_mode_t m, input int kind, input int n,
                                 input int gapPct, input int latAt, input int stallAt);
        int lat;
        int held;
        fillImage(kind);
        pushExpected(n, m);
        for (int k = 0; k < n; k++) begin
            if (k > 0 && int'($urandom_range(0, 99)) < gapPct) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            sendPixel(img[k], (k == 0), (k == 0) ? m : kernel_mode_t'($urandom_range(0, 3)));
            if (k == latAt) begin
                lat = 0;
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!outValid && lat < 10);
                checkOutput("latency", lat, 2);
            end
            if (k == stallAt) begin
                lat = 0;
                while (!outValid && lat < 20) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                held     = int'(outPixel);
                outReady = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stallInReady", int'(inReady), 0);
                    checkOutput("stallValid", int'(outValid), 1);
                    checkOutput("stallPixel", int'(outPixel), held);
                end
                @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        end
    endtask

    task automatic drainOutputs();
        int cyc;
        cyc = 0;
        while (expQ.size() > 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("drain", expQ.size(), 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Valid"}, int'(outValid), 0);
        checkOutput({tag, "Pixel"}, int'(outPixel), 0);
        checkOutput({tag, "Sof"}, int'(outSof), 0);
        checkOutput({tag, "Eof"}, int'(outEof), 0);
        checkOutput({tag, "InReady"}, int'(inReady), 1);
    endtask

    // Consumes one expectation per output beat and checks that stalled outputs hold still.
    initial begin
        bit      wasStalled;
        int      heldPixel;
        expect_t e;
        wasStalled = 1'b0;
        heldPixel  = 0;
        forever begin
            @(negedge clk);
            if (rstN && outValid) begin
                if (wasStalled) checkOutput("heldPixel", int'(outPixel), heldPixel);
                if (outReady) begin
                    checkOutput("expectPending", int'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("pixel", int'(outPixel), e.pix);
                        checkOutput("sof", int'(outSof), e.sof);
                        checkOutput("eof", int'(outEof), e.eof);
                    end
                    wasStalled = 1'b0;
                end else begin
                    wasStalled = 1'b1;
                    heldPixel  = int'(outPixel);
                end
            end else begin
                wasStalled = 1'b0;
            end
        end
    end

    // Random downstream backpressure, applied only while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bpEnable) outReady = (int'($urandom_range(0, 99)) >= 30);
        end
    end

    initial begin
        clk        = 1'b0;
        rstN       = 1'b0;
        mode       = GAUSS;
        inValid    = 1'b0;
        inSof      = 1'b0;
        inPixel    = '0;
        outReady   = 1'b1;
        sel        = 1'b0;
        bpEnable   = 1'b0;
        checkCount = 0;
        failCount  = 0;
        curW       = SMALL_W;
        curH       = SMALL_H;

        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] flat field, all modes");
        applyStimulus(GAUSS, IMG_FLAT, 25, 0, 12, -1);
        drainOutputs();
        applyStimulus(SOBEL_X, IMG_FLAT, 25, 0, -1, -1);
        applyStimulus(SOBEL_Y, IMG_FLAT, 25, 0, -1, -1);
        applyStimulus(MAG, IMG_FLAT, 25, 0, -1, -1);
        drainOutputs();

        $display("[TB] step edges");
        applyStimulus(SOBEL_X, IMG_VSTEP, 25, 0, -1, -1);
        applyStimulus(SOBEL_Y, IMG_VSTEP, 25, 0, -1, -1);
        applyStimulus(MAG, IMG_HSTEP, 25, 0, -1, -1);
        drainOutputs();

        $display("[TB] held output stall");
        applyStimulus(MAG, IMG_RANDOM, 25, 0, -1, 14);
        drainOutputs();

        $display("[TB] random frames with backpressure and mode scrambling");
        bpEnable = 1'b1;
        for (int f = 0; f < 8; f++) begin
            applyStimulus(kernel_mode_t'($urandom_range(0, 3)), IMG_RANDOM, 25, 20, -1, -1);
        end
        applyStimulus(MAG, IMG_RANDOM, 25, 20, -1, -1);
        applyStimulus(GAUSS, IMG_RANDOM, 25, 20, -1, -1);
        drainOutputs();

        $display("[TB] abandoned frame resynchronised by sof");
        applyStimulus(SOBEL_Y, IMG_RANDOM, 17, 10, -1, -1);
        applyStimulus(SOBEL_X, IMG_RANDOM, 25, 10, -1, -1);
        drainOutputs();
        bpEnable = 1'b0;
        outReady = 1'b1;

        $display("[TB] reset mid-frame");
        applyStimulus(GAUSS, IMG_RANDOM, 16, 0, -1, -1);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        checkIdleOutputs("midReset");
        rstN = 1'b1;
        applyStimulus(MAG, IMG_RANDOM, 25, 0, -1, -1);
        drainOutputs();

        $display("[TB] wide image random compare");
        sel      = 1'b1;
        curW     = BIG_W;
        curH     = BIG_H;
        bpEnable = 1'b1;
        applyStimulus(kernel_mode_t'($urandom_range(0, 3)), IMG_RANDOM, BIG_W * BIG_H, 10, -1, -1);
        drainOutputs();
        bpEnable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
